keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; `clk` and `clr` are the clock and reset ports.
REQ-002 Parameter SCAN_DIV_W, default 12: width of the column-dwell divider, so dwell = 2^SCAN_DIV_W cycles.
REQ-003 Parameter DEB_SCANS, default 4: identical consecutive full frames required to commit the key map; legal range 2..15.
REQ-004 Port `clk`  in  1: system clock.
REQ-005 Port `clr`  in  1: synchronous active-high reset.
REQ-006 Port `row`  in  4: keypad rows; active-low; pulled up externally; asynchronous to `clk`.
REQ-007 Port `col`  out  4: keypad column drive; active-low; exactly one bit low at any time.
REQ-008 Port `key_code`  out  4: hex code of the last pressed key.
REQ-009 Port `key_valid`  out  1: one-cycle pulse when `key_code` updates.
REQ-010 Port `key_down`  out  1: committed map is non-zero.
REQ-011 Port `key_multi`  out  1: committed map has 2 or more keys.
REQ-012 Port `hex_buf`  out  32: last 8 key codes, newest in bits [3:0]; drives the 8-digit display x input directly.

Function
REQ-013 `row` SHALL pass through a 2-flop synchronizer before any use.
REQ-014 The divider SHALL free-run; `tick` is asserted when the divider equals all-ones.
REQ-015 `col_idx` (0..3) SHALL advance by 1 the cycle after `tick`, wrapping 3->0.
REQ-016 `col` SHALL equal ~(4'b0001 << col_idx).
REQ-017 On `tick`, the inverted synchronized `row` SHALL be written to raw[col_idx*4 +: 4], giving 2^SCAN_DIV_W-1 cycles of settling.
REQ-018 The `tick` with col_idx==3 SHALL raise `frame_done` for one cycle on the next cycle.
REQ-019 FSM states are SCAN, EVAL and COMMIT: SCAN->EVAL on `frame_done`; EVAL->COMMIT when the commit condition holds; otherwise EVAL->SCAN; COMMIT->SCAN always (1 cycle).
REQ-020 EVAL, raw != cand: cand <= raw, stab_cnt <= 0.
REQ-021 EVAL, raw == cand and stab_cnt < DEB_SCANS-1: stab_cnt <= stab_cnt+1.
REQ-022 EVAL, raw == cand and stab_cnt == DEB_SCANS-1: enter COMMIT; stab_cnt holds at DEB_SCANS-1, so a held map does not re-commit new events.
REQ-023 In COMMIT: stable <= cand; `key_down` = |cand; `key_multi` = popcount(cand) >= 2.
REQ-024 Press event SHALL fire when the old stable == 0 and popcount(cand) == 1; key_valid=1 for the COMMIT cycle only.
REQ-025 On a press event, key_code = KEY_LUT[index of set bit] and hex_buf <= {hex_buf[27:0], code}.
REQ-026 KEY_LUT, indexed [col*4+row], row 0..3 top to bottom, col 0..3 left to right, SHALL encode this layout: row0 "1 2 3 A", row1 "4 5 6 B", row2 "7 8 9 C", row3 "E 0 F D"; E is '*' and F is '#'.
REQ-027 Transitions from 1 to 2+ keys, from 2+ to 1 key, and releases SHALL generate no event.
REQ-028 A key held through its release SHALL need a commit of map==0 before the next press event fires.
REQ-029 Event latency SHALL be at most (DEB_SCANS+1) frames + 3 cycles from a stable press.
REQ-030 A raw change inside the debounce window SHALL restart the count; bounce shorter than one frame never commits.

Reset
REQ-031 While `clr`=1 at a `clk` edge, the following SHALL reset:
- divider, col_idx, stab_cnt, raw, cand, stable <= 0;
- col <= 4'b1110, FSM <= SCAN;
- key_code, key_valid, key_down, key_multi <= 0; hex_buf <= 32'h0;
- synchronizer flops <= 4'hF.
REQ-032 A reset mid-frame or mid-debounce SHALL discard partial data; scanning restarts at col 0 the cycle after `clr` deasserts.

Structure
REQ-033 Package keypad_pkg SHALL hold the FSM state enum, the KEY_LUT constant (16 x 4 bits) and NCOL = NROW = 4.
REQ-034 One sub-module, sync_2ff (parameterized width, reset value), SHALL implement the row synchronizer.
REQ-035 Popcount and priority-index SHALL be plain combinational logic in keypad_scan.

Verification (SCAN_DIV_W=2, DEB_SCANS=4; frame = 16 cycles)
REQ-036 Idle after reset:
- stimulus: `row`=4'hF for 10 frames;
- required: `col` cycles 1110,1101,1011,0111 every 4 cycles; key_valid is never asserted; hex_buf == 0.
REQ-037 Single press:
- stimulus: hold row1 low while `col`[2] is low (key '6') for 8 frames, then release;
- required: exactly one key_valid, with key_code=4'h6 and hex_buf=32'h00000006; key_down falls at most 5 frames after release.
REQ-038 Bounce:
- stimulus: toggle key '0' every 20 cycles for 6 frames, then hold it;
- required: no key_valid during the toggling; exactly one key_valid with code 4'h0 after the hold.
REQ-039 Multi-key:
- stimulus: press '1', commit, add 'D', then release '1';
- required: a single key_valid (code 1); key_multi=1 while both are held; no event when 'D' becomes the sole key.
REQ-040 Sequence:
- stimulus: press and release 1,2,3,A,4,5,6,B,7 in turn;
- required: hex_buf = 32'h23A456B7.
REQ-041 Reset mid-debounce:
- stimulus: assert `clr` for 1 cycle at stab_cnt=2 with '9' held;
- required: all outputs at their reset values the next cycle; '9' commits only after a full 4-frame debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// KEY_LUT is indexed by col*4+row and holds the hex code printed on each key.
package keypad_pkg;

    localparam int NCOL = 4;
    localparam int NROW = 4;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_EVAL,
        ST_COMMIT
    } state_t;

    // Entry 15 first: {D,C,B,A, F,9,6,3, 0,8,5,2, E,7,4,1}
    localparam logic [15:0][3:0] KEY_LUT = {
        4'hD, 4'hC, 4'hB, 4'hA,
        4'hF, 4'h9, 4'h6, 4'h3,
        4'h0, 4'h8, 4'h5, 4'h2,
        4'hE, 4'h7, 4'h4, 4'h1
    };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both stages load RST on clr so a reset looks like an idle input.
module sync_2ff #(
    parameter int           W   = 4,
    parameter logic [W-1:0] RST = '1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            s1_q <= RST;
            s2_q <= RST;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with whole-frame debounce and press events.
// A frame is four column dwells; a map must repeat DEB_SCANS frames to commit.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W = 12,
    parameter int DEB_SCANS  = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic        key_multi,
    output logic [31:0] hex_buf
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_SCANS - 1);

    logic [3:0]            row_s;
    logic [SCAN_DIV_W-1:0] div_q;
    logic [1:0]            col_idx_q;
    logic [3:0]            col_q;
    logic [15:0]           raw_q;
    logic [15:0]           cand_q;
    logic [15:0]           stable_q;
    logic [3:0]            stab_q;
    logic                  frame_q;
    state_t                state_q;
    logic [3:0]            code_q;
    logic                  valid_q;
    logic                  down_q;
    logic                  multi_q;
    logic [31:0]           hex_q;
    logic                  tick;
    logic [4:0]            pop;
    logic [3:0]            idx;

    sync_2ff #(.W(4), .RST(4'hF)) u_sync (
        .clk (clk),
        .clr (clr),
        .d_i (row),
        .q_o (row_s)
    );

    assign tick = &div_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            raw_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            div_q   <= div_q + 1'b1;
            frame_q <= tick && (col_idx_q == 2'd3);
            if (tick) begin
                // Sampled at the end of the dwell so the rows have settled
                raw_q[{col_idx_q, 2'b00} +: 4] <= ~row_s;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
            end
        end
    end

    // Lowest set bit wins; only used when exactly one key is down
    always_comb begin
        pop = '0;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (cand_q[i]) begin
                pop = pop + 5'd1;
                idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_SCAN;
            cand_q   <= '0;
            stable_q <= '0;
            stab_q   <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            down_q   <= 1'b0;
            multi_q  <= 1'b0;
            hex_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                ST_SCAN: begin
                    if (frame_q)
                        state_q <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (raw_q != cand_q) begin
                        cand_q  <= raw_q;
                        stab_q  <= '0;
                        state_q <= ST_SCAN;
                    end else if (stab_q < DEB_LAST) begin
                        stab_q  <= stab_q + 4'd1;
                        state_q <= ST_SCAN;
                    end else begin
                        state_q  <= ST_COMMIT;
                        stable_q <= cand_q;
                        down_q   <= |cand_q;
                        multi_q  <= (pop >= 5'd2);
                        if (stable_q == '0 && pop == 5'd1) begin
                            valid_q <= 1'b1;
                            code_q  <= KEY_LUT[idx];
                            hex_q   <= {hex_q[27:0], KEY_LUT[idx]};
                        end
                    end
                end
                ST_COMMIT: state_q <= ST_SCAN;
                default:   state_q <= ST_SCAN;
            endcase
        end
    end

    assign col       = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;
    assign key_multi = multi_q;
    assign hex_buf   = hex_q;

endmodule
